// File: rtl/window_3x3_gen.sv
// 3x3 RGB444 neighbourhood generator over a raster pixel stream, using two line buffers.
// Latency: 1 clk from the accepting edge of the bottom-right pixel to win_valid and color_data.
// Backpressure: none; every pix_valid cycle is consumed, and idle cycles leave all outputs held.
module window_3x3_gen #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pix_valid,
    input  logic         pix_sof,
    input  logic [11:0]  pix_data,
    output logic [107:0] color_data,
    output logic         win_valid,
    output logic [9:0]   win_x,
    output logic [9:0]   win_y,
    output logic         frame_done
);

    localparam int         AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);

    // Position of the next accepted pixel
    logic [9:0]   col_q, col_d;
    logic [9:0]   row_q, row_d;
    // Position of the pixel on the input this cycle (sof forces 0,0)
    logic [9:0]   cur_col, cur_row;

    // Line buffers: row-1 and row-2 relative to the incoming pixel; never reset,
    // because rows 0 and 1 of every frame rewrite them before a window reads them
    logic [11:0]  lb_mid_q [IMG_W];
    logic [11:0]  lb_top_q [IMG_W];
    logic [AW-1:0] lb_addr;
    logic [11:0]  top_rd, mid_rd;

    // Window registers indexed [row][column]; row 0 = top, column 0 = leftmost (oldest)
    logic [2:0][2:0][11:0] win_q, win_d;

    logic [107:0] color_data_q, color_data_d;
    logic         win_valid_q, win_valid_d;
    logic [9:0]   win_x_q, win_x_d;
    logic [9:0]   win_y_q, win_y_d;
    logic         frame_done_q, frame_done_d;

    // Counter advance, window shift and output capture for the pixel on the input
    always_comb begin
        cur_col      = pix_sof ? 10'd0 : col_q;
        cur_row      = pix_sof ? 10'd0 : row_q;
        lb_addr      = cur_col[AW-1:0];
        top_rd       = lb_top_q[lb_addr];
        mid_rd       = lb_mid_q[lb_addr];

        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        color_data_d = color_data_q;
        win_valid_d  = 1'b0;
        win_x_d      = win_x_q;
        win_y_d      = win_y_q;
        frame_done_d = 1'b0;

        if (pix_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = 10'd0;
                row_d = (cur_row == ROW_LAST) ? 10'd0 : cur_row + 10'd1;
            end else begin
                col_d = cur_col + 10'd1;
                row_d = cur_row;
            end

            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = top_rd;
            win_d[1][2] = mid_rd;
            win_d[2][2] = pix_data;

            // Centre is one column and one row behind the incoming pixel, so
            // border centres are skipped by requiring col>=2 and row>=2
            if (cur_col >= 10'd2 && cur_row >= 10'd2) begin
                win_valid_d  = 1'b1;
                win_x_d      = cur_col - 10'd1;
                win_y_d      = cur_row - 10'd1;
                frame_done_d = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
                color_data_d = {win_d[1][1], win_d[1][0], win_d[1][2],
                                win_d[0][1], win_d[2][1],
                                win_d[0][0], win_d[0][2],
                                win_d[2][0], win_d[2][2]};
            end
        end
    end

    // Control, window and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q        <= 10'd0;
            row_q        <= 10'd0;
            win_q        <= '0;
            color_data_q <= '0;
            win_valid_q  <= 1'b0;
            win_x_q      <= 10'd0;
            win_y_q      <= 10'd0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            color_data_q <= color_data_d;
            win_valid_q  <= win_valid_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer update: the middle row ages into the top row at the same column
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb_top_q[lb_addr] <= mid_rd;
            lb_mid_q[lb_addr] <= pix_data;
        end
    end

    assign color_data = color_data_q;
    assign win_valid  = win_valid_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;

    localparam logic [107:0] CENTRE11 = 108'h011_010_012_001_021_000_002_020_022;

    logic         clk;
    logic         reset;

    // Small 4x4 instance
    logic         s_pix_valid, s_pix_sof;
    logic [11:0]  s_pix_data;
    logic [107:0] s_color_data;
    logic         s_win_valid, s_frame_done;
    logic [9:0]   s_win_x, s_win_y;

    // Full-size 160x120 instance
    logic         b_pix_valid, b_pix_sof;
    logic [11:0]  b_pix_data;
    logic [107:0] b_color_data;
    logic         b_win_valid, b_frame_done;
    logic [9:0]   b_win_x, b_win_y;

    int checks;
    int failures;

    logic [11:0]  img [0:119][0:159];
    logic [107:0] h_data;
    logic [9:0]   h_x, h_y;
    logic [107:0] first_win;
    logic [9:0]   first_x, first_y;

    window_3x3_gen #(.IMG_W(4), .IMG_H(4)) u_small (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (s_pix_valid),
        .pix_sof    (s_pix_sof),
        .pix_data   (s_pix_data),
        .color_data (s_color_data),
        .win_valid  (s_win_valid),
        .win_x      (s_win_x),
        .win_y      (s_win_y),
        .frame_done (s_frame_done)
    );

    window_3x3_gen #(.IMG_W(160), .IMG_H(120)) u_big (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (b_pix_valid),
        .pix_sof    (b_pix_sof),
        .pix_data   (b_pix_data),
        .color_data (b_color_data),
        .win_valid  (b_win_valid),
        .win_x      (b_win_x),
        .win_y      (b_win_y),
        .frame_done (b_frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Software reference: window around centre (x,y) of the image in img
    function automatic logic [107:0] model(input int x, input int y);
        return {img[y][x],   img[y][x-1],   img[y][x+1],
                img[y-1][x], img[y+1][x],
                img[y-1][x-1], img[y-1][x+1],
                img[y+1][x-1], img[y+1][x+1]};
    endfunction

    task automatic s_send(input logic [11:0] d, input logic sof);
        s_pix_valid = 1'b1;
        s_pix_data  = d;
        s_pix_sof   = sof;
        @(posedge clk);
        #1;
        s_pix_valid = 1'b0;
        s_pix_sof   = 1'b0;
    endtask

    task automatic b_send(input logic [11:0] d, input logic sof);
        b_pix_valid = 1'b1;
        b_pix_data  = d;
        b_pix_sof   = sof;
        @(posedge clk);
        #1;
        b_pix_valid = 1'b0;
        b_pix_sof   = 1'b0;
    endtask

    // Streams one 4x4 frame from img into the small instance, checking every accept
    // and every idle cycle; idle cycles also hold pix_sof high without pix_valid
    task automatic small_frame(input bit sof_first, input int max_idle, input string tag);
        int nwin;
        int ndone;
        int n;
        logic [107:0] exp;
        bit got_first;
        nwin = 0;
        ndone = 0;
        got_first = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (max_idle > 0 && !(r == 0 && c == 0)) begin
                    n = $urandom_range(0, max_idle);
                    for (int k = 0; k < n; k++) begin
                        s_pix_sof = 1'b1;
                        @(posedge clk);
                        #1;
                        checks++;
                        if (s_win_valid !== 1'b0 || s_frame_done !== 1'b0 ||
                            s_color_data !== h_data || s_win_x !== h_x || s_win_y !== h_y) begin
                            failures++;
                            $display("FAIL %s_idle r%0d c%0d: got v=%b fd=%b x=%0d y=%0d d=%h, want v=0 fd=0 x=%0d y=%0d d=%h",
                                     tag, r, c, s_win_valid, s_frame_done, s_win_x, s_win_y, s_color_data, h_x, h_y, h_data);
                        end
                    end
                    s_pix_sof = 1'b0;
                end
                s_send(img[r][c], sof_first && r == 0 && c == 0);
                checks++;
                if (c >= 2 && r >= 2) begin
                    exp = model(c - 1, r - 1);
                    if (s_win_valid !== 1'b1 || s_win_x !== 10'(c - 1) || s_win_y !== 10'(r - 1) ||
                        s_frame_done !== (c == 3 && r == 3) || s_color_data !== exp) begin
                        failures++;
                        $display("FAIL %s_win r%0d c%0d: got v=%b fd=%b x=%0d y=%0d d=%h, want v=1 fd=%b x=%0d y=%0d d=%h",
                                 tag, r, c, s_win_valid, s_frame_done, s_win_x, s_win_y, s_color_data,
                                 (c == 3 && r == 3), c - 1, r - 1, exp);
                    end
                    h_data = exp;
                    h_x    = 10'(c - 1);
                    h_y    = 10'(r - 1);
                end else begin
                    if (s_win_valid !== 1'b0 || s_frame_done !== 1'b0 || s_color_data !== h_data ||
                        s_win_x !== h_x || s_win_y !== h_y) begin
                        failures++;
                        $display("FAIL %s_nowin r%0d c%0d: got v=%b fd=%b x=%0d y=%0d d=%h, want v=0 fd=0 x=%0d y=%0d d=%h",
                                 tag, r, c, s_win_valid, s_frame_done, s_win_x, s_win_y, s_color_data, h_x, h_y, h_data);
                    end
                end
                if (s_win_valid === 1'b1) begin
                    nwin++;
                    if (!got_first) begin
                        got_first = 1;
                        first_win = s_color_data;
                        first_x   = s_win_x;
                        first_y   = s_win_y;
                    end
                end
                if (s_frame_done === 1'b1) ndone++;
            end
        end
        checks++;
        if (nwin != 4) begin
            failures++;
            $display("FAIL %s_count: got %0d windows, want 4", tag, nwin);
        end
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL %s_done_count: got %0d frame_done pulses, want 1", tag, ndone);
        end
    endtask

    task automatic check_first(input string tag);
        checks++;
        if (first_win !== CENTRE11 || first_x !== 10'd1 || first_y !== 10'd1) begin
            failures++;
            $display("FAIL %s_first: got x=%0d y=%0d d=%h, want x=1 y=1 d=%h",
                     tag, first_x, first_y, first_win, CENTRE11);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (s_color_data !== 108'd0 || s_win_valid !== 1'b0 || s_win_x !== 10'd0 ||
            s_win_y !== 10'd0 || s_frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_small: got v=%b fd=%b x=%0d y=%0d d=%h, want all 0",
                     s_win_valid, s_frame_done, s_win_x, s_win_y, s_color_data);
        end
        checks++;
        if (b_color_data !== 108'd0 || b_win_valid !== 1'b0 || b_win_x !== 10'd0 ||
            b_win_y !== 10'd0 || b_frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_big: got v=%b fd=%b x=%0d y=%0d d=%h, want all 0",
                     b_win_valid, b_frame_done, b_win_x, b_win_y, b_color_data);
        end
        h_data = '0;
        h_x    = '0;
        h_y    = '0;
    endtask

    task automatic test_frame;
        small_frame(1'b1, 0, "frame");
        check_first("frame");
    endtask

    task automatic test_hold;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s_win_valid !== 1'b0 || s_frame_done !== 1'b0 || s_color_data !== h_data ||
                s_win_x !== 10'd2 || s_win_y !== 10'd2) begin
                failures++;
                $display("FAIL hold %0d: got v=%b fd=%b x=%0d y=%0d d=%h, want v=0 fd=0 x=2 y=2 d=%h",
                         k, s_win_valid, s_frame_done, s_win_x, s_win_y, s_color_data, h_data);
            end
        end
    endtask

    task automatic test_idle;
        small_frame(1'b1, 3, "idle");
        check_first("idle");
    endtask

    task automatic test_sof_mid;
        for (int i = 0; i < 6; i++) begin
            s_send(12'hF00 + 12'(i), 1'b0);
            checks++;
            if (s_win_valid !== 1'b0 || s_color_data !== h_data) begin
                failures++;
                $display("FAIL sof_pre %0d: got v=%b d=%h, want v=0 d=%h", i, s_win_valid, s_color_data, h_data);
            end
        end
        small_frame(1'b1, 0, "sof");
        check_first("sof");
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 9; i++) s_send(img[i / 4][i % 4], i == 0);
        reset = 1'b1;
        #2;
        checks++;
        if (s_color_data !== 108'd0 || s_win_valid !== 1'b0 || s_win_x !== 10'd0 ||
            s_win_y !== 10'd0 || s_frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got v=%b fd=%b x=%0d y=%0d d=%h, want all 0",
                     s_win_valid, s_frame_done, s_win_x, s_win_y, s_color_data);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        h_data = '0;
        h_x    = '0;
        h_y    = '0;
        small_frame(1'b0, 0, "rstframe");
        check_first("rstframe");
    endtask

    task automatic test_big;
        int nwin;
        int ndone;
        logic [107:0] exp;
        ndone = 0;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 120; r++)
                for (int c = 0; c < 160; c++)
                    img[r][c] = 12'($urandom_range(0, 4095));
            nwin = 0;
            for (int r = 0; r < 120; r++) begin
                for (int c = 0; c < 160; c++) begin
                    b_send(img[r][c], f == 0 && r == 0 && c == 0);
                    checks++;
                    if (c >= 2 && r >= 2) begin
                        exp = model(c - 1, r - 1);
                        if (b_win_valid !== 1'b1 || b_win_x !== 10'(c - 1) || b_win_y !== 10'(r - 1) ||
                            b_frame_done !== (c == 159 && r == 119) || b_color_data !== exp) begin
                            failures++;
                            $display("FAIL big_win f%0d r%0d c%0d: got v=%b fd=%b x=%0d y=%0d d=%h, want v=1 x=%0d y=%0d d=%h",
                                     f, r, c, b_win_valid, b_frame_done, b_win_x, b_win_y, b_color_data, c - 1, r - 1, exp);
                        end
                    end else begin
                        if (b_win_valid !== 1'b0 || b_frame_done !== 1'b0) begin
                            failures++;
                            $display("FAIL big_nowin f%0d r%0d c%0d: got v=%b fd=%b, want v=0 fd=0",
                                     f, r, c, b_win_valid, b_frame_done);
                        end
                    end
                    if (b_win_valid === 1'b1) nwin++;
                    if (b_frame_done === 1'b1) ndone++;
                end
            end
            checks++;
            if (nwin != 18644) begin
                failures++;
                $display("FAIL big_count f%0d: got %0d windows, want 18644", f, nwin);
            end
        end
        checks++;
        if (ndone != 2) begin
            failures++;
            $display("FAIL big_done_count: got %0d, want 2", ndone);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        s_pix_valid = 1'b0;
        s_pix_sof   = 1'b0;
        s_pix_data  = '0;
        b_pix_valid = 1'b0;
        b_pix_sof   = 1'b0;
        b_pix_data  = '0;
        first_win   = '0;
        first_x     = '0;
        first_y     = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r][c] = 12'(r * 16 + c);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        test_reset;
        test_frame;
        test_hold;
        test_idle;
        test_sof_mid;
        test_reset_mid;
        test_big;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
